// File: rtl/coax_pkg.sv
// Shared definitions for the coax multi-channel receive front-end.
//   DEFAULT_DATA_WIDTH : default coax word width
//   state_e            : drain state machine encoding (IDLE / HOLDOFF)
//   ch_idx_w(n)        : width of a channel index, max(1, clog2(n))
package coax_pkg;

  localparam int DEFAULT_DATA_WIDTH = 10;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_HOLDOFF = 1'b1
  } state_e;

  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/coax_rx_channel_mux_if.sv
// Tagged output word stream from the channel mux to the control block.
//   out_data    : merged coax word
//   out_channel : source channel of out_data
//   out_error   : receiver error flag of the source channel at capture
//   out_valid   : word valid
//   out_ready   : consumer accepts the word
// master = the mux (producer), slave = the consumer.
interface coax_rx_channel_mux_if #(
  parameter int DATA_WIDTH = coax_pkg::DEFAULT_DATA_WIDTH,
  parameter int CW         = 2
);

  logic [DATA_WIDTH-1:0] out_data;
  logic [CW-1:0]         out_channel;
  logic                  out_error;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_channel,
    output out_error,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_channel,
    input  out_error,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/coax_rr_arbiter.sv
// Combinational rotating-priority encoder.
//   req       : request vector, one bit per channel
//   ptr       : last granted channel; search starts at ptr+1 and wraps
//   grant     : index of the first requesting channel after ptr
//   any_grant : at least one request present
module coax_rr_arbiter
  import coax_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = ch_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [CW-1:0] grant,
  output logic          any_grant
);

  // Walk the candidates from lowest priority (ptr+N, i.e. ptr itself) to
  // highest (ptr+1); the last hit wins, which is the first one after ptr.
  always_comb begin
    logic [CW-1:0] idx;
    grant     = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = CW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant     = idx;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coax_rx_channel_mux.sv
// Multi-channel coax receive front-end.
// Conditions each raw rx pin (synchroniser, loopback, tx gating) into
// rx_line for a per-channel buffered receiver, drains those receivers'
// first-word-fall-through FIFOs round-robin into one tagged valid/ready
// stream, and raises a maskable aggregated interrupt.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   rx_pin            : raw asynchronous receive line per channel
//   tx_line/tx_active : per-channel internal serial tx and tx-active flag
//   loopback          : per-channel loopback enable
//   rx_line           : conditioned line to each receiver
//   ch_active/ch_error: per-channel receiver status
//   ch_data/ch_empty  : per-channel FIFO head word and empty flag
//   ch_read_strobe    : one-cycle FIFO pop per channel
//   irq_mask          : 1 = channel excluded from irq
//   out_if            : merged output stream (master side)
//   irq               : registered aggregated interrupt
module coax_rx_channel_mux
  import coax_pkg::*;
#(
  parameter  int CHANNELS    = 4,
  parameter  int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter  int SYNC_STAGES = 2,
  localparam int CW          = ch_idx_w(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            rx_pin,
  input  logic [CHANNELS-1:0]            tx_line,
  input  logic [CHANNELS-1:0]            tx_active,
  input  logic [CHANNELS-1:0]            loopback,
  output logic [CHANNELS-1:0]            rx_line,
  input  logic [CHANNELS-1:0]            ch_active,
  input  logic [CHANNELS-1:0]            ch_error,
  input  logic [CHANNELS*DATA_WIDTH-1:0] ch_data,
  input  logic [CHANNELS-1:0]            ch_empty,
  output logic [CHANNELS-1:0]            ch_read_strobe,
  input  logic [CHANNELS-1:0]            irq_mask,
  coax_rx_channel_mux_if.master          out_if,
  output logic                           irq
);

  logic [DATA_WIDTH-1:0] ch_word [CHANNELS];

  // ---- rx conditioning: synchroniser then combinational select ----
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin[i]};
      end
    end

    assign rx_line[i] = loopback[i]  ? tx_line[i] :
                        tx_active[i] ? 1'b0       :
                                       sync_q[SYNC_STAGES-1];

    assign ch_word[i] = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---- arbitration over non-empty FIFOs ----
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] grant;
  logic          any_grant;

  coax_rr_arbiter #(
    .N (CHANNELS)
  ) u_arb (
    .req       (~ch_empty),
    .ptr       (ptr_q),
    .grant     (grant),
    .any_grant (any_grant)
  );

  // ---- drain FSM and output register stage ----
  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         chan_q, chan_d;
  logic                  err_q, err_d;
  logic [CHANNELS-1:0]   strobe_q, strobe_d;
  logic                  irq_q, irq_d;
  logic                  slot_free;

  assign slot_free = !valid_q || out_if.out_ready;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    valid_d  = valid_q;
    data_d   = data_q;
    chan_d   = chan_q;
    err_d    = err_q;
    strobe_d = '0;

    // Any accepted word with nothing to replace it leaves the slot empty.
    if (valid_q && out_if.out_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (slot_free && any_grant) begin
          valid_d         = 1'b1;
          data_d          = ch_word[grant];
          chan_d          = grant;
          err_d           = ch_error[grant];
          strobe_d[grant] = 1'b1;
          ptr_d           = grant;
          state_d         = ST_HOLDOFF;
        end
      end
      // ch_empty of the popped channel is still stale this cycle.
      ST_HOLDOFF: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign irq_d = |((ch_active | ch_error | ~ch_empty) & ~irq_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= CW'(CHANNELS - 1);
      valid_q  <= 1'b0;
      data_q   <= '0;
      chan_q   <= '0;
      err_q    <= 1'b0;
      strobe_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      chan_q   <= chan_d;
      err_q    <= err_d;
      strobe_q <= strobe_d;
      irq_q    <= irq_d;
    end
  end

  assign out_if.out_valid   = valid_q;
  assign out_if.out_data    = data_q;
  assign out_if.out_channel = chan_q;
  assign out_if.out_error   = err_q;
  assign ch_read_strobe     = strobe_q;
  assign irq                = irq_q;

endmodule

// File: doc/coax_rx_channel_mux.md
Name: coax_rx_channel_mux

Overview:
- Multi-channel receive front-end for the coax interface.
- Conditions N raw coax receive lines: synchroniser, loopback select, and gating while the channel is transmitting. Each conditioned line drives one coax_buffered_rx instance.
- Round-robin drains those receivers' word FIFOs into a single tagged valid/ready stream for the control block, and aggregates a maskable interrupt.
- Generalises the single-channel rx conditioning and irq glue to CHANNELS channels, and adds arbitration.

Parameters:
- CHANNELS, 4, number of coax channels (1..16).
- DATA_WIDTH, 10, coax word width.
- SYNC_STAGES, 2, flops in each rx pin synchroniser (>=2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_pin  in  CHANNELS  raw receive line per channel (asynchronous)
- tx_line  in  CHANNELS  internal serial tx per channel
- tx_active  in  CHANNELS  channel transmitter active
- loopback  in  CHANNELS  per-channel loopback enable
- rx_line  out  CHANNELS  conditioned line to each coax_buffered_rx
- ch_active  in  CHANNELS  receiver active per channel
- ch_error  in  CHANNELS  receiver error per channel
- ch_data  in  CHANNELS*DATA_WIDTH  head word per channel; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- ch_empty  in  CHANNELS  receiver FIFO empty per channel
- ch_read_strobe  out  CHANNELS  one-cycle pop per channel
- irq_mask  in  CHANNELS  1 = channel excluded from irq
- out_data  out  DATA_WIDTH  merged word
- out_channel  out  CW  source channel; CW = max(1, clog2(CHANNELS))
- out_error  out  1  ch_error of source channel at capture
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the word
- irq  out  1  aggregated interrupt

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values:
  - Synchroniser flops 0.
  - out_valid 0; out_data, out_channel, out_error 0.
  - ch_read_strobe 0; irq 0.
  - Round-robin pointer = CHANNELS-1, so channel 0 is checked first.
  - State = IDLE.
- Conditioning, per channel i:
  - sync_i is rx_pin[i] delayed through SYNC_STAGES flops.
  - rx_line[i] = loopback[i] ? tx_line[i] : (tx_active[i] ? 0 : sync_i).
  - The select is combinational after the synchroniser. Pin-to-rx_line latency is exactly SYNC_STAGES cycles.
- ch_data is first-word-fall-through: it is valid whenever !ch_empty. A pop is one ch_read_strobe cycle; ch_empty reflects the pop one cycle later.
- State machine (IDLE, HOLDOFF):
  - IDLE, when slot free and a channel is eligible:
    - Slot free = !out_valid || out_ready.
    - Eligible = !ch_empty.
    - Grant g = first eligible channel searched from pointer+1, with wrap-around.
    - Next cycle: out_data = ch_data[g], out_channel = g, out_error = ch_error[g], out_valid = 1.
    - ch_read_strobe[g] pulses for that same single cycle. Pointer = g. State goes to HOLDOFF.
  - HOLDOFF: lasts one cycle, makes no grant, returns to IDLE. This masks stale ch_empty. Maximum throughput is one word per 2 cycles.
  - IDLE with slot free and no eligible channel: if out_ready, out_valid drops to 0.
  - out_valid && !out_ready: output registers hold stable, no grant.
- Simultaneous accept and grant: when out_ready is high in the same cycle as a grant, the new word replaces the old one with no bubble.
- At most one ch_read_strobe bit is high in any cycle. A strobe is never issued to a channel whose ch_empty is high.
- irq is registered: irq = OR over i of ((ch_active[i] | ch_error[i] | !ch_empty[i]) & !irq_mask[i]). Latency is 1 cycle.
- Reset while out_valid=1: the word is dropped, and out_valid=0 on the next cycle.
- CHANNELS=1: the pointer is constant, and out_channel = 0.

Decomposition:
- Package coax_pkg:
  - DEFAULT_DATA_WIDTH = 10.
  - The state encoding (IDLE, HOLDOFF).
  - The channel index width function max(1, clog2(n)).
- Sub-module coax_rr_arbiter:
  - Parameter N.
  - Inputs: request vector, pointer.
  - Outputs: grant index, any_grant.
  - Purely combinational rotate-priority-encode; instantiated once.
- Synchronisers are written inline as a generate loop.

Test Plan:
- Conditioning, CHANNELS=4:
  - rx_pin[2] rises at cycle 10 -> rx_line[2] rises at cycle 12.
  - With tx_active[2]=1, rx_line[2]=0.
  - With loopback[2]=1, rx_line[2] follows tx_line[2] in the same cycle.
- Round-robin: channels 0, 1 and 3 each hold 2 words (0x101.., 0x202.., 0x303..), out_ready=1 -> output order 0,1,3,0,1,3. Exactly 6 strobes, 2 cycles apart, and out_channel matches each word.
- Backpressure:
  - With out_ready=0 for 20 cycles, out_data and out_channel stay stable and no further strobes occur.
  - With out_ready=1, the next word follows with no loss or duplication.
- Error tag: ch_error[1]=1 while channel 1 holds word 0x3FF -> out_data=0x3FF, out_channel=1, out_error=1.
- irq:
  - ch_active[3]=1 with irq_mask=4'b1000 -> irq=0.
  - Clearing the mask -> irq=1 one cycle later.
  - Channel 0 non-empty with mask 0 -> irq=1.
- Reset mid-operation: assert reset with out_valid=1 and channel 2 non-empty -> next cycle out_valid=0 and strobes=0. The first grant after reset goes to the lowest non-empty channel (0 if 0 is non-empty).
